mm_r2mm_un: RTL and testbench

Parametrised radix-2 Montgomery multiplier. It computes res = x*y*2^-K mod m using U bit-serial R2MM steps chained combinationally per clock, so one multiplication takes K/U iteration cycles plus one final-subtraction cycle. It is the successor to the fixed two-step multiplier, and adds:
- a configurable unroll factor
- operand capture at accept
- a busy/req handshake
- a registered final-subtraction stage

It is the modular-multiply core under the IDDMM exponentiation datapath.

---
 rtl/mm_pkg.sv | 20 ++
 rtl/mm_r2mm_un_if.sv | 15 +
 rtl/mm_r2mm_step.sv | 23 ++
 rtl/mm_r2mm_un.sv | 114 +++++++++++
 tb/tb_mm_r2mm_un.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier: state encoding
// and the iteration-counter width helper.
package mm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        SUB  = ST_SUB
    } state_e;

    // Counter must hold 0 .. K/U inclusive.
    function automatic int unsigned cnt_width(input int unsigned k, input int unsigned u);
        return $clog2(k / u + 1);
    endfunction

endpackage

// File: rtl/mm_r2mm_un_if.sv
// Request/result bus of the Montgomery multiplier core.
interface mm_r2mm_un_if #(
    parameter int unsigned K = 256
);
    logic         req;
    logic [K-1:0] x;
    logic [K-1:0] y;
    logic [K-1:0] m;
    logic         busy;
    logic [K-1:0] res;
    logic         val;

    modport master (output req, x, y, m, input busy, res, val);
    modport slave  (input req, x, y, m, output busy, res, val);
endinterface

// File: rtl/mm_r2mm_step.sv
// One combinational radix-2 Montgomery step: so = (si + xi*y + q*m) / 2.
module mm_r2mm_step #(
    parameter int unsigned K = 256
) (
    input  logic         xi,
    input  logic [K-1:0] y,
    input  logic [K-1:0] m,
    input  logic [K:0]   si,
    output logic [K:0]   so
);
    logic [K+1:0] t;
    logic [K+1:0] u;
    logic         q;

    // The sum is even by construction, so the shift drops only a zero bit.
    always_comb begin
        t  = {1'b0, si} + (xi ? {2'b00, y} : (K+2)'(0));
        q  = t[0];
        u  = t + (q ? {2'b00, m} : (K+2)'(0));
        so = (K+1)'(u >> 1);
    end

endmodule

// File: rtl/mm_r2mm_un.sv
// Radix-2 Montgomery multiplier, U steps per clock, res = x*y*2^-K mod m,
// with a registered final conditional subtraction.
module mm_r2mm_un
    import mm_pkg::*;
#(
    parameter int unsigned K = 256,
    parameter int unsigned U = 2
) (
    input  logic          clk,
    input  logic          rst,
    mm_r2mm_un_if.slave   bus
);
    localparam int unsigned CW  = cnt_width(K, U);
    localparam int unsigned NIT = K / U;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [K-1:0]  x_q,     x_d;
    logic [K-1:0]  y_q,     y_d;
    logic [K-1:0]  m_q,     m_d;
    logic [K:0]    s_q,     s_d;
    logic [K-1:0]  res_q,   res_d;
    logic          val_q,   val_d;
    logic          busy_q,  busy_d;

    logic [K:0]    chain [0:U];

    // Unrolled step chain; x_q is shifted down so its low U bits are current.
    assign chain[0] = s_q;

    for (genvar g = 0; g < U; g++) begin : g_step
        mm_r2mm_step #(.K(K)) u_step (
            .xi (x_q[g]),
            .y  (y_q),
            .m  (m_q),
            .si (chain[g]),
            .so (chain[g+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            s_q     <= '0;
            res_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            m_q     <= m_d;
            s_q     <= s_d;
            res_q   <= res_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        m_d     = m_q;
        s_d     = s_q;
        res_d   = res_q;
        val_d   = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    x_d     = bus.x;
                    y_d     = bus.y;
                    m_d     = bus.m;
                    s_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d   = chain[U];
                x_d   = x_q >> U;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NIT - 1)) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                // s < 2m, so one conditional subtraction fully reduces it.
                res_d   = (s_q >= {1'b0, m_q}) ? (s_q[K-1:0] - m_q) : s_q[K-1:0];
                val_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.res  = res_q;
    assign bus.val  = val_q;

endmodule

// File: tb/tb_mm_r2mm_un.sv
// Directed and randomized checks of mm_r2mm_un: K=8/U=2 handshake cases and a
// K=256 sweep over U in {1,2,4,8} against a modular-arithmetic reference.
module tb_mm_r2mm_un;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q [$];

    mm_r2mm_un_if #(.K(8)) b8 ();
    mm_r2mm_un #(.K(8), .U(2)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    logic         sw_req;
    logic [255:0] sw_x, sw_y, sw_m;
    logic         sw_val [4];
    logic [255:0] sw_res [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        mm_r2mm_un_if #(.K(256)) b ();
        assign b.req     = sw_req;
        assign b.x       = sw_x;
        assign b.y       = sw_y;
        assign b.m       = sw_m;
        assign sw_val[g] = b.val;
        assign sw_res[g] = b.res;
        mm_r2mm_un #(.K(256), .U(1 << g)) dut (.clk(clk), .rst(rst), .bus(b));
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // x*y*2^-k mod m via shift-add modular product followed by k modular halvings.
    function automatic logic [257:0] mont_ref(input logic [257:0] x, input logic [257:0] y,
                                              input logic [257:0] m, input int k);
        logic [257:0] r;
        r = '0;
        for (int i = k - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= m) r = r - m;
            if (y[i]) begin
                r = r + x;
                if (r >= m) r = r - m;
            end
        end
        for (int i = 0; i < k; i++) begin
            if (r[0]) r = r + m;
            r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] m);
        b8.x   = x;
        b8.y   = y;
        b8.m   = m;
        b8.req = 1'b1;
        step();
        b8.req = 1'b0;
    endtask

    task automatic wait_val(input string tag, input int exp_lat, input bit chk_res);
        int n = 0;
        logic [7:0] e;
        while (n < 40) begin
            step();
            n++;
            if (b8.val === 1'b1) break;
            chk({tag, "_busy"}, 256'(b8.busy), 256'(1));
        end
        chk({tag, "_val"}, 256'(b8.val), 256'(1));
        if (b8.val === 1'b1) begin
            chk({tag, "_lat"}, 256'(n), 256'(exp_lat));
            chk({tag, "_busy_end"}, 256'(b8.busy), 256'(0));
            if (chk_res) begin
                chk({tag, "_sb_nonempty"}, 256'(exp_q.size() > 0), 256'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({tag, "_res"}, 256'(b8.res), 256'(e));
                end
            end
        end
    endtask

    initial begin
        bit seen [4];
        bit saw_val;
        int n;
        logic [257:0] ev;

        b8.req = 1'b0; b8.x = '0; b8.y = '0; b8.m = '0;
        sw_req = 1'b0; sw_x = '0; sw_y = '0; sw_m = '0;

        step();
        step();
        chk("rst_busy", 256'(b8.busy), 256'(0));
        chk("rst_val",  256'(b8.val),  256'(0));
        chk("rst_res",  256'(b8.res),  256'(0));
        rst = 1'b0;
        step();

        exp_q.push_back(8'hE1);
        start8(8'h01, 8'h01, 8'hF1);
        chk("t1_busy_accept", 256'(b8.busy), 256'(1));
        wait_val("t1", 5, 1'b1);
        step();
        chk("t1_pulse", 256'(b8.val), 256'(0));
        chk("t1_hold",  256'(b8.res), 256'(8'hE1));

        exp_q.push_back(8'h01);
        start8(8'h0F, 8'h01, 8'hF1);
        wait_val("t2", 5, 1'b1);

        exp_q.push_back(8'hE1);
        start8(8'hF0, 8'hF0, 8'hF1);
        wait_val("t3", 5, 1'b1);

        // Request in the val cycle is accepted on the next edge.
        exp_q.push_back(8'h01);
        start8(8'h0F, 8'h01, 8'hF1);
        wait_val("b2b", 5, 1'b1);

        exp_q.push_back(8'h00);
        start8(8'h00, 8'hA5, 8'hF1);
        wait_val("t4", 5, 1'b1);

        // Requests and operand changes while busy must not disturb the run.
        exp_q.push_back(8'h01);
        start8(8'h0F, 8'h01, 8'hF1);
        step();
        b8.req = 1'b1; b8.x = 8'hF0; b8.y = 8'hF0; b8.m = 8'h11;
        step();
        b8.req = 1'b0; b8.x = 8'h33; b8.y = 8'h77; b8.m = 8'h0A;
        wait_val("hs", 3, 1'b1);
        saw_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (b8.val === 1'b1) saw_val = 1'b1;
        end
        chk("hs_not_queued", 256'(saw_val), 256'(0));

        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE1);
        b8.x = 8'h01; b8.y = 8'h01; b8.m = 8'hF1; b8.req = 1'b1;
        step();
        wait_val("cont1", 5, 1'b1);
        step();
        b8.req = 1'b0;
        wait_val("cont2", 5, 1'b1);

        // Asynchronous reset aborts an operation in flight.
        start8(8'h01, 8'h01, 8'hF1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("arst_busy", 256'(b8.busy), 256'(0));
        chk("arst_val",  256'(b8.val),  256'(0));
        chk("arst_res",  256'(b8.res),  256'(0));
        step();
        rst = 1'b0;
        saw_val = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (b8.val === 1'b1) saw_val = 1'b1;
        end
        chk("arst_no_val", 256'(saw_val), 256'(0));
        exp_q.push_back(8'h01);
        start8(8'h0F, 8'h01, 8'hF1);
        wait_val("arst_after", 5, 1'b1);

        start8(8'h03, 8'h05, 8'hF0);
        wait_val("even_m", 5, 1'b0);

        for (int v = 0; v < 3; v++) begin
            sw_m = rand256() | 256'(1) | (256'(1) << 255);
            if (v == 0) begin
                sw_x = sw_m - 256'(1);
                sw_y = sw_m - 256'(1);
            end else begin
                sw_x = rand256() % sw_m;
                sw_y = rand256() % sw_m;
            end
            ev = mont_ref({2'b00, sw_x}, {2'b00, sw_y}, {2'b00, sw_m}, 256);
            sw_req = 1'b1;
            step();
            sw_req = 1'b0;
            sw_x = rand256();
            for (int j = 0; j < 4; j++) seen[j] = 1'b0;
            n = 0;
            while (n < 300 && !(seen[0] && seen[1] && seen[2] && seen[3])) begin
                step();
                n++;
                for (int j = 0; j < 4; j++) begin
                    if (sw_val[j] === 1'b1 && !seen[j]) begin
                        seen[j] = 1'b1;
                        chk($sformatf("sweep%0d_u%0d_res", v, 1 << j), sw_res[j], ev[255:0]);
                        chk($sformatf("sweep%0d_u%0d_lat", v, 1 << j), 256'(n), 256'(256 / (1 << j) + 1));
                    end
                end
            end
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("sweep%0d_u%0d_done", v, 1 << j), 256'(seen[j]), 256'(1));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
